// File: rtl/stack_unit.sv
// Stack/call controller: runs PUSH/POP/CALL/RET against a req/ack data-memory port and issues
// one-cycle SP/LR/PC commit strobes. Define STACK_INIT_EN to load SP with STACK_TOP after reset.
module stack_unit #(
  parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic [31:0] cur_sp,
  input  logic [31:0] cur_lr,
  input  logic [31:0] cur_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wr_sp,
  output logic        wr_lr,
  output logic        wr_pc,
  output logic [31:0] wr_sp_data,
  output logic [31:0] wr_lr_data,
  output logic [31:0] wr_pc_data,
  output logic        pop_valid,
  output logic [31:0] pop_data,
  output logic        done,
  output logic        err,
  output logic        fault
);

  localparam logic [1:0] OpPush = 2'd0;
  localparam logic [1:0] OpPop  = 2'd1;
  localparam logic [1:0] OpCall = 2'd2;
  localparam logic [1:0] OpRet  = 2'd3;

  typedef enum logic [1:0] {StIdle, StMem, StCommit, StInit} state_e;

`ifdef STACK_INIT_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [31:0] sp_q, sp_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bad_q, bad_d;
  logic        fault_q, fault_d;

  logic [31:0] cur_sp_dec, cur_sp_inc, sp_dec_q, sp_inc_q;
  logic        cur_grows, grows_q, chk_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ResetState;
      op_q    <= 2'd0;
      data_q  <= 32'd0;
      sp_q    <= 32'd0;
      lr_q    <= 32'd0;
      pc_q    <= 32'd0;
      rdata_q <= 32'd0;
      bad_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      sp_q    <= sp_d;
      lr_q    <= lr_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      bad_q   <= bad_d;
      fault_q <= fault_d;
    end
  end

  // PUSH and CALL grow the stack downward; POP and RET shrink it.
  assign cur_grows  = (cmd_op == OpPush) || (cmd_op == OpCall);
  assign grows_q    = (op_q == OpPush) || (op_q == OpCall);
  assign cur_sp_dec = cur_sp - 32'd4;
  assign cur_sp_inc = cur_sp + 32'd4;
  assign sp_dec_q   = sp_q - 32'd4;
  assign sp_inc_q   = sp_q + 32'd4;
  assign chk_fault  = (cur_sp[1:0] != 2'b00) ||
                      (cur_grows ? (cur_sp_dec < STACK_LIMIT) : (cur_sp_inc > STACK_TOP));
  assign fault      = fault_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    sp_d       = sp_q;
    lr_d       = lr_q;
    pc_d       = pc_q;
    rdata_d    = rdata_q;
    bad_d      = bad_q;
    fault_d    = fault_q;
    cmd_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    wr_sp      = 1'b0;
    wr_lr      = 1'b0;
    wr_pc      = 1'b0;
    wr_sp_data = 32'd0;
    wr_lr_data = 32'd0;
    wr_pc_data = 32'd0;
    pop_valid  = 1'b0;
    pop_data   = 32'd0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          sp_d    = cur_sp;
          lr_d    = cur_lr;
          pc_d    = cur_pc;
          bad_d   = chk_fault || fault_q;
          state_d = (chk_fault || fault_q) ? StCommit : StMem;
        end
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_we    = grows_q;
        mem_addr  = grows_q ? sp_dec_q : sp_q;
        mem_wdata = (op_q == OpCall) ? lr_q : ((op_q == OpPush) ? data_q : 32'd0);
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = StCommit;
        end
      end
      StCommit: begin
        done    = 1'b1;
        state_d = StIdle;
        if (bad_q) begin
          err     = 1'b1;
          fault_d = 1'b1;
        end else begin
          wr_sp      = 1'b1;
          wr_sp_data = grows_q ? sp_dec_q : sp_inc_q;
          unique case (op_q)
            OpPush: ;
            OpPop: begin
              pop_valid = 1'b1;
              pop_data  = rdata_q;
            end
            OpCall: begin
              wr_lr      = 1'b1;
              wr_lr_data = pc_q + 32'd4;
              wr_pc      = 1'b1;
              wr_pc_data = data_q;
            end
            OpRet: begin
              wr_pc      = 1'b1;
              wr_pc_data = lr_q;
              wr_lr      = 1'b1;
              wr_lr_data = rdata_q;
            end
            default: ;
          endcase
        end
      end
`ifdef STACK_INIT_EN
      StInit: begin
        // Held here while reset is high; the SP load fires in the first cycle after release.
        wr_sp      = !reset;
        wr_sp_data = reset ? 32'd0 : STACK_TOP;
        state_d    = StIdle;
      end
`else
      StInit: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_stack_unit.sv
// Randomized bench for stack_unit: a per-command reference model predicts memory traffic,
// commit strobes, latency and the sticky fault flag.
module tb_stack_unit;

  localparam logic [31:0] Top   = 32'h0000_1000;
  localparam logic [31:0] Limit = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready;
  logic [31:0] cur_sp = 32'd0, cur_lr = 32'd0, cur_pc = 32'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wr_sp, wr_lr, wr_pc;
  logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        done, err, fault;

  int n_checks = 0;
  int n_errors = 0;
  bit model_fault = 1'b0;

  always #5 clk = ~clk;

  stack_unit dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .cur_sp     (cur_sp),
    .cur_lr     (cur_lr),
    .cur_pc     (cur_pc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wr_sp      (wr_sp),
    .wr_lr      (wr_lr),
    .wr_pc      (wr_pc),
    .wr_sp_data (wr_sp_data),
    .wr_lr_data (wr_lr_data),
    .wr_pc_data (wr_pc_data),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .done       (done),
    .err        (err),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    cmd_valid = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_strobes", {29'd0, wr_sp, wr_lr, wr_pc}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_fault = 1'b0;
    @(negedge clk);
`ifdef STACK_INIT_EN
    check("init_wr_sp", {31'd0, wr_sp}, 32'd1);
    check("init_wr_sp_data", wr_sp_data, Top);
    check("init_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
`endif
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_wr_sp", {31'd0, wr_sp}, 32'd0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] data, input logic [31:0] sp,
                         input logic [31:0] lr, input logic [31:0] pc, input int delay,
                         input logic [31:0] rdata);
    logic [31:0] sp_m4, sp_p4, e_addr, e_wdata, e_sp_d, e_lr_d, e_pc_d, e_pop_d;
    logic [31:0] a0, w0, o_sp_d, o_lr_d, o_pc_d, o_pop_d;
    bit grows, e_fault, e_wlr, e_wpc, e_pv, we0, unstable, got_done;
    bit o_sp, o_lr, o_pc, o_pv, o_err;
    int e_lat, e_mem, mem_n, lat, stray, w;

    sp_m4 = sp - 32'd4;
    sp_p4 = sp + 32'd4;
    grows = (op == 2'd0) || (op == 2'd2);
    e_fault = model_fault || (sp[1:0] != 2'b00) || (grows ? (sp_m4 < Limit) : (sp_p4 > Top));
    e_mem = e_fault ? 0 : delay + 1;
    e_lat = e_fault ? 1 : delay + 2;
    e_addr = grows ? sp_m4 : sp;
    e_wdata = (op == 2'd0) ? data : ((op == 2'd2) ? lr : 32'd0);
    e_sp_d = 32'd0; e_lr_d = 32'd0; e_pc_d = 32'd0; e_pop_d = 32'd0;
    e_wlr = 1'b0; e_wpc = 1'b0; e_pv = 1'b0;
    if (!e_fault) begin
      e_sp_d = grows ? sp_m4 : sp_p4;
      case (op)
        2'd1: begin e_pv = 1'b1; e_pop_d = rdata; end
        2'd2: begin e_wlr = 1'b1; e_lr_d = pc + 32'd4; e_wpc = 1'b1; e_pc_d = data; end
        2'd3: begin e_wlr = 1'b1; e_lr_d = rdata; e_wpc = 1'b1; e_pc_d = lr; end
        default: ;
      endcase
    end

    @(posedge clk);
    #1 cmd_valid = 1'b1;
    cmd_op = op; cmd_data = data; cur_sp = sp; cur_lr = lr; cur_pc = pc;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("fault_flag", {31'd0, fault}, {31'd0, model_fault});
    @(posedge clk);
    // Keep offering junk: the unit must not take it while busy, and must use latched operands.
    #1 cmd_op = 2'($urandom); cmd_data = $urandom;
    cur_sp = $urandom; cur_lr = $urandom; cur_pc = $urandom;

    mem_n = 0; lat = 0; stray = 0; unstable = 1'b0; got_done = 1'b0;
    a0 = 32'd0; w0 = 32'd0; we0 = 1'b0;
    o_sp = 0; o_lr = 0; o_pc = 0; o_pv = 0; o_err = 0;
    o_sp_d = 0; o_lr_d = 0; o_pc_d = 0; o_pop_d = 0;
    for (int n = 1; n <= e_lat + 8 && !got_done; n++) begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_n == 0) begin
          a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
          unstable = 1'b1;
        end
        mem_ack = (mem_n == delay);
        mem_rdata = (mem_n == delay) ? rdata : $urandom;
        mem_n++;
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        got_done = 1'b1; lat = n;
        o_sp = wr_sp; o_lr = wr_lr; o_pc = wr_pc; o_pv = pop_valid; o_err = err;
        o_sp_d = wr_sp_data; o_lr_d = wr_lr_data; o_pc_d = wr_pc_data; o_pop_d = pop_data;
        cmd_valid = 1'b0;
      end else if (wr_sp || wr_lr || wr_pc || pop_valid || err ||
                   wr_sp_data != 0 || wr_lr_data != 0 || wr_pc_data != 0 || pop_data != 0) begin
        stray++;
      end
    end
    mem_ack = 1'b0;
    cmd_valid = 1'b0;

    check("latency", lat, e_lat);
    check("mem_cycles", mem_n, e_mem);
    if (e_mem > 0) begin
      check("mem_addr", a0, e_addr);
      check("mem_we", {31'd0, we0}, {31'd0, grows});
      check("mem_wdata", w0, e_wdata);
      check("mem_stable", {31'd0, unstable}, 32'd0);
    end
    check("stray_strobes", stray, 0);
    check("err", {31'd0, o_err}, {31'd0, e_fault});
    check("wr_sp", {31'd0, o_sp}, {31'd0, !e_fault});
    check("wr_sp_data", o_sp_d, e_sp_d);
    check("wr_lr", {31'd0, o_lr}, {31'd0, e_wlr});
    check("wr_lr_data", o_lr_d, e_lr_d);
    check("wr_pc", {31'd0, o_pc}, {31'd0, e_wpc});
    check("wr_pc_data", o_pc_d, e_pc_d);
    check("pop_valid", {31'd0, o_pv}, {31'd0, e_pv});
    check("pop_data", o_pop_d, e_pop_d);
    model_fault = model_fault || e_fault;
  endtask

  task automatic abort_in_mem();
    @(posedge clk);
    #1 cmd_valid = 1'b1;
    cmd_op = 2'd0; cmd_data = 32'hA5A5_0000; cur_sp = 32'h0000_0F00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("abort_in_mem", {31'd0, mem_req}, 32'd1);
    do_reset();
  endtask

  initial begin
    logic [31:0] sp;
    do_reset();

    run_cmd(2'd0, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0, 32'h0, 2, 32'h0);
    run_cmd(2'd1, 32'h0, 32'h0000_0FFC, 32'h0, 32'h0, 0, 32'h1234_5678);
    run_cmd(2'd2, 32'h0000_0200, 32'h0000_1000, 32'h0000_0099, 32'h0000_0040, 1, 32'h0);
    run_cmd(2'd3, 32'h0, 32'h0000_0FFC, 32'h0000_0044, 32'h0000_0300, 0, 32'h0000_0099);

    run_cmd(2'd1, 32'h0, 32'h0000_1000, 32'h0, 32'h0, 0, 32'h0);
    run_cmd(2'd0, 32'h1, 32'h0000_0F00, 32'h0, 32'h0, 0, 32'h0);
    do_reset();
    run_cmd(2'd0, 32'h2, 32'h0000_0802, 32'h0, 32'h0, 0, 32'h0);
    do_reset();
    run_cmd(2'd0, 32'h3, 32'h0000_0800, 32'h0, 32'h0, 0, 32'h0);
    do_reset();
    run_cmd(2'd2, 32'h4, 32'h0000_0804, 32'h5, 32'hFFFF_FFFC, 0, 32'h0);

    abort_in_mem();

    for (int i = 0; i < 150; i++) begin
      sp = 32'($urandom_range(32'h1FF, 32'h400)) << 2;
      if ($urandom_range(0, 15) == 0) sp = sp + 32'($urandom_range(1, 3));
      run_cmd(2'($urandom), $urandom, sp, $urandom, $urandom, $urandom_range(0, 3), $urandom);
      if (model_fault && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
